// File: rtl/regfile_pkg.sv
// Shared types for the integer register file and its pending-write scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 2;
  localparam int unsigned CNT_MAX   = (1 << CNT_W_DEF) - 1;

  typedef logic [4:0]          reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

  typedef struct packed {
    logic     wb_en;
    reg_idx_t wb_rd;
    xlen_t    wb_data;
  } rf_wr_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/write-back side bundle of the register file: WB port, two read ports, issue port.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = 32
);
  logic            wb_en;
  reg_idx_t        wb_rd;
  logic [XLEN-1:0] wb_data;
  reg_idx_t        rs1_addr;
  reg_idx_t        rs2_addr;
  logic            rs1_used;
  logic            rs2_used;
  logic            iss_valid;
  logic            iss_wb;
  reg_idx_t        iss_rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            stall;
  logic            sb_err;

  modport master (
    output wb_en, wb_rd, wb_data, rs1_addr, rs2_addr, rs1_used, rs2_used,
           iss_valid, iss_wb, iss_rd,
    input  rs1_data, rs2_data, stall, sb_err
  );

  modport slave (
    input  wb_en, wb_rd, wb_data, rs1_addr, rs2_addr, rs1_used, rs2_used,
           iss_valid, iss_wb, iss_rd,
    output rs1_data, rs2_data, stall, sb_err
  );
endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// Per-register pending-writer counter; inc and dec together leave it unchanged.
module sb_counter
  import regfile_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o,
  output logic             full_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i)      cnt_d = cnt_q + CNT_W'(1);
    else if (dec_i && !inc_i) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign full_o = &cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file x0..x(NREGS-1) with write-through bypass and a pending-write scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 arst_n,
  regfile_scoreboard_if.slave  bus
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [CNT_W-1:0] cnt    [NREGS];
  logic             zero_v [NREGS];
  logic             full_v [NREGS];
  logic             hz1, hz2, full, acc;
  logic             sb_err_q, sb_err_d;

  // x0 never has producers in flight
  assign cnt[0]    = '0;
  assign zero_v[0] = 1'b1;
  assign full_v[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    logic inc, dec;
    assign inc = acc && (bus.iss_rd == reg_idx_t'(r));
    assign dec = bus.wb_en && (bus.wb_rd == reg_idx_t'(r)) && !zero_v[r];
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .inc_i  (inc),
      .dec_i  (dec),
      .cnt_o  (cnt[r]),
      .zero_o (zero_v[r]),
      .full_o (full_v[r])
    );
  end

  // A source stops waiting the cycle its last producer retires; the bypass carries the value.
  assign hz1 = bus.rs1_used && (bus.rs1_addr != '0) && !zero_v[bus.rs1_addr]
            && !(bus.wb_en && (bus.wb_rd == bus.rs1_addr) && (cnt[bus.rs1_addr] == CNT_W'(1)));
  assign hz2 = bus.rs2_used && (bus.rs2_addr != '0) && !zero_v[bus.rs2_addr]
            && !(bus.wb_en && (bus.wb_rd == bus.rs2_addr) && (cnt[bus.rs2_addr] == CNT_W'(1)));
  assign full = bus.iss_wb && (bus.iss_rd != '0) && full_v[bus.iss_rd]
             && !(bus.wb_en && (bus.wb_rd == bus.iss_rd));

  assign bus.stall = bus.iss_valid && (hz1 || hz2 || full);
  assign acc       = bus.iss_valid && !bus.stall && bus.iss_wb && (bus.iss_rd != '0);

  assign bus.rs1_data = (bus.rs1_addr == '0) ? '0 :
                        (bus.wb_en && (bus.wb_rd == bus.rs1_addr)) ? bus.wb_data :
                        regs_q[bus.rs1_addr];
  assign bus.rs2_data = (bus.rs2_addr == '0) ? '0 :
                        (bus.wb_en && (bus.wb_rd == bus.rs2_addr)) ? bus.wb_data :
                        regs_q[bus.rs2_addr];

  assign sb_err_d   = sb_err_q || (bus.wb_en && (bus.wb_rd != '0) && zero_v[bus.wb_rd]);
  assign bus.sb_err = sb_err_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      sb_err_q <= 1'b0;
    end else begin
      if (bus.wb_en && (bus.wb_rd != '0)) regs_q[bus.wb_rd] <= bus.wb_data;
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized checks of regfile_scoreboard against a behavioural model.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.XLEN(32)) bus ();

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .CNT_W(2)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int errs  = 0;
  int total = 0;

  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.wb_en && bus.wb_rd == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  function automatic int m_left(input logic [4:0] a);
    return m_cnt[a] - ((bus.wb_en && bus.wb_rd == a && m_cnt[a] > 0) ? 1 : 0);
  endfunction

  // Wait while any producer of a source will still be in flight after this cycle.
  function automatic logic m_stall();
    logic w1, w2, fl;
    w1 = bus.rs1_used && bus.rs1_addr != 5'd0 && m_left(bus.rs1_addr) > 0;
    w2 = bus.rs2_used && bus.rs2_addr != 5'd0 && m_left(bus.rs2_addr) > 0;
    fl = bus.iss_wb && bus.iss_rd != 5'd0 &&
         (m_cnt[bus.iss_rd] - ((bus.wb_en && bus.wb_rd == bus.iss_rd) ? 1 : 0)) >= int'(CNT_MAX);
    return bus.iss_valid && (w1 || w2 || fl);
  endfunction

  task automatic drive(input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                       input logic iv, input logic iw, input logic [4:0] ird);
    bus.wb_en = we;  bus.wb_rd = wrd;  bus.wb_data = wd;
    bus.rs1_addr = a1; bus.rs2_addr = a2; bus.rs1_used = u1; bus.rs2_used = u2;
    bus.iss_valid = iv; bus.iss_wb = iw; bus.iss_rd = ird;
  endtask

  task automatic step(input string tag);
    logic acc;
    #1;
    check({tag, ".rs1"},   bus.rs1_data, m_read(bus.rs1_addr));
    check({tag, ".rs2"},   bus.rs2_data, m_read(bus.rs2_addr));
    check({tag, ".stall"}, {31'd0, bus.stall},  {31'd0, m_stall()});
    check({tag, ".err"},   {31'd0, bus.sb_err}, {31'd0, m_err});
    acc = bus.iss_valid && !m_stall() && bus.iss_wb && bus.iss_rd != 5'd0;
    @(posedge clk);
    if (bus.wb_en && bus.wb_rd != 5'd0) begin
      if (m_cnt[bus.wb_rd] == 0) m_err = 1'b1;
      else m_cnt[bus.wb_rd]--;
      m_regs[bus.wb_rd] = bus.wb_data;
    end
    if (acc) m_cnt[bus.iss_rd]++;
    #1;
  endtask

  task automatic do_reset(input string tag);
    arst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin m_regs[i] = 32'd0; m_cnt[i] = 0; end
    m_err = 1'b0;
    #2;
    check({tag, ".err"},   {31'd0, bus.sb_err}, 32'd0);
    check({tag, ".stall"}, {31'd0, bus.stall},  {31'd0, m_stall()});
    check({tag, ".rs1"},   bus.rs1_data, m_read(bus.rs1_addr));
    #1;
    arst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] cand;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset("reset");

    // 1: plain write then read next cycle
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 5);                       step("t1.iss");
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);           step("t1.wb");
    drive(0, 0, 0, 5, 0, 1, 0, 0, 0, 0);
    #1 check("t1.rd", bus.rs1_data, 32'hDEAD_BEEF);            step("t1.read");

    // 2: same-cycle bypass
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 7);                       step("t2.iss");
    drive(1, 7, 32'h1234, 0, 7, 0, 1, 0, 0, 0);
    #1 check("t2.byp", bus.rs2_data, 32'h1234);                step("t2.wb");

    // 3: x0 is hardwired, issue to x0 is ignored
    drive(1, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 1, 1, 0);
    #1 check("t3.x0byp", bus.rs1_data, 32'd0);
    check("t3.stall", {31'd0, bus.stall}, 32'd0);              step("t3.wb");
    drive(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    #1 check("t3.x0rd", bus.rs1_data, 32'd0);                  step("t3.read");

    // 4: RAW hazard resolved by write-back with bypass
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 3);                       step("t4.iss");
    drive(0, 0, 0, 3, 0, 1, 0, 1, 0, 0);
    #1 check("t4.stall", {31'd0, bus.stall}, 32'd1);           step("t4.hold");
    drive(1, 3, 32'h55, 3, 0, 1, 0, 1, 0, 0);
    #1 check("t4.go", {31'd0, bus.stall}, 32'd0);
    check("t4.data", bus.rs1_data, 32'h55);                    step("t4.wb");

    // 5: full counter
    repeat (3) begin drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 9);      step("t5.iss"); end
    #1 check("t5.full", {31'd0, bus.stall}, 32'd1);            step("t5.fullstep");
    drive(1, 9, 32'hAA, 0, 0, 0, 0, 1, 1, 9);
    #1 check("t5.swap", {31'd0, bus.stall}, 32'd0);            step("t5.swapstep");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 9);
    #1 check("t5.still", {31'd0, bus.stall}, 32'd1);           step("t5.stillstep");
    repeat (3) begin drive(1, 9, 32'hBB, 0, 0, 0, 0, 0, 0, 0); step("t5.ret"); end
    #1 check("t5.noerr", {31'd0, bus.sb_err}, 32'd0);

    // 6: sticky error, cleared only by reset
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset("t6.rst0");
    drive(1, 12, 32'h77, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t6.pre", {31'd0, bus.sb_err}, 32'd0);            step("t6.wb");
    drive(0, 0, 0, 12, 0, 0, 0, 1, 1, 4);
    #1 check("t6.set", {31'd0, bus.sb_err}, 32'd1);
    check("t6.data", bus.rs1_data, 32'h77);                    step("t6.iss");
    drive(0, 0, 0, 4, 0, 1, 0, 1, 0, 0);
    #1 check("t6.sticky", {31'd0, bus.sb_err}, 32'd1);
    check("t6.haz", {31'd0, bus.stall}, 32'd1);
    do_reset("t6.rst");
    check("t6.stallclr", {31'd0, bus.stall}, 32'd0);
    step("t6.after");

    // Random traffic, write-backs biased toward registers with producers in flight
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 99) do_reset("rnd.rst");
      cand = 5'($urandom_range(0, 7));
      for (int k = 0; k < 6; k++)
        if (m_cnt[cand] == 0) cand = 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), cand, $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)));
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule
